// File: rtl/serial_comp_pkg.sv
// Shared types for the serial magnitude comparator.
// Holds the FSM state encoding and the slice width.
package serial_comp_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_comp_ctrl_if.sv
// Request/result bundle of the serial comparator.
// master: start, a, b out; busy, done, gt, eq, lt in. slave: reverse.
interface serial_comp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, a, b,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/comp2_slice.sv
// Combinational compare of one 2-bit operand slice.
// Ports: x, y slice values in; gt, eq, lt one-hot result out.
module comp2_slice
    import serial_comp_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    output logic               gt,
    output logic               eq,
    output logic               lt
);

    assign gt = (x > y);
    assign eq = (x == y);
    assign lt = (x < y);

endmodule

// File: rtl/serial_comp_ctrl.sv
// Serial unsigned comparator, 2 bits per cycle, MSB first, early exit.
// Ports: clk, rst (sync, active-high), start/a/b in; busy/done/gt/eq/lt out.
module serial_comp_ctrl
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("serial_comp_ctrl: WIDTH must be even and >= 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [SLICE_W-1:0] sx, sy;
    logic               s_gt, s_eq, s_lt;

    // Slice k sits k slices below the MSB of the latched operands.
    always_comb begin
        sx = '0;
        sy = '0;
        for (int i = 0; i < NSL; i++) begin
            if (k_q == KW'(i)) begin
                sx = opa_q[WIDTH-1-SLICE_W*i -: SLICE_W];
                sy = opb_q[WIDTH-1-SLICE_W*i -: SLICE_W];
            end
        end
    end

    comp2_slice u_slice (
        .x  (sx),
        .y  (sy),
        .gt (s_gt),
        .eq (s_eq),
        .lt (s_lt)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        k_d     = k_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CMP;
                    opa_d   = a;
                    opb_d   = b;
                    k_d     = '0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            CMP: begin
                // An equal slice can only finish the compare when it is
                // the last one, so s_eq doubles as the final eq flag.
                if (!s_eq || k_q == K_LAST) begin
                    state_d = DONE;
                    gt_d    = s_gt;
                    eq_d    = s_eq;
                    lt_d    = s_lt;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CMP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed bench for serial_comp_ctrl: vector table plus corner sequences.
// Drives on negedge, samples on negedge; WIDTH=8 and WIDTH=2 instances.
module tb_serial_comp_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_comp_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_comp_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_comp_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (bus8.start),
        .a     (bus8.a),
        .b     (bus8.b),
        .busy  (bus8.busy),
        .done  (bus8.done),
        .gt    (bus8.gt),
        .eq    (bus8.eq),
        .lt    (bus8.lt)
    );

    serial_comp_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (bus2.start),
        .a     (bus2.a),
        .b     (bus2.b),
        .busy  (bus2.busy),
        .done  (bus2.done),
        .gt    (bus2.gt),
        .eq    (bus2.eq),
        .lt    (bus2.lt)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;   // {gt, eq, lt}
        int         lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] flags8();
        return {bus8.gt, bus8.eq, bus8.lt};
    endfunction

    function automatic logic [2:0] flags2();
        return {bus2.gt, bus2.eq, bus2.lt};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge
    // where done is seen (or after the budget expires).
    task automatic run(input bit w2, input logic [7:0] av,
                       input logic [7:0] bv, output int lat,
                       output logic [2:0] fl, output int busy_n);
        if (w2) begin
            bus2.start = 1'b1;
            bus2.a     = av[1:0];
            bus2.b     = bv[1:0];
        end else begin
            bus8.start = 1'b1;
            bus8.a     = av;
            bus8.b     = bv;
        end
        @(negedge clk);
        bus8.start = 1'b0;
        bus2.start = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!(w2 ? bus2.done : bus8.done) && lat < 20) begin
            if (w2 ? bus2.busy : bus8.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        fl = w2 ? flags2() : flags8();
    endtask

    vec_t       vt [10];
    int         lat, busy_n, n, nd, di;
    logic [2:0] fl, fd;
    logic [5:0] dpat, bpat;
    logic       bb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'hA5, 8'hA5, 3'b010, 4};
        vt[1] = '{8'hC0, 8'h40, 3'b100, 1};
        vt[2] = '{8'h12, 8'h13, 3'b001, 4};
        vt[3] = '{8'h80, 8'h00, 3'b100, 1};
        vt[4] = '{8'h30, 8'h20, 3'b100, 2};
        vt[5] = '{8'h04, 8'h0C, 3'b001, 3};
        vt[6] = '{8'hFF, 8'hFF, 3'b010, 4};
        vt[7] = '{8'h00, 8'h00, 3'b010, 4};
        vt[8] = '{8'h7F, 8'h80, 3'b001, 1};
        vt[9] = '{8'hFE, 8'hFF, 3'b001, 4};

        // Reset with start held high: reset must win.
        rst        = 1'b1;
        bus8.start = 1'b1;
        bus8.a     = 8'h00;
        bus8.b     = 8'h00;
        bus2.start = 1'b0;
        bus2.a     = 2'b00;
        bus2.b     = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_outs8", {bus8.busy, bus8.done, flags8()}, 5'b0);
        chk("reset_outs2", {bus2.busy, bus2.done, flags2()}, 5'b0);

        // Start accepted on first edge with rst low.
        rst = 1'b0;
        @(negedge clk);
        chk("start_first_edge", bus8.busy, 1'b1);
        bus8.start = 1'b0;
        n = 0;
        while (!bus8.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_cmp_lat", n, 4);
        chk("first_cmp_flags", flags8(), 3'b010);
        @(negedge clk);

        // Table vectors.
        for (int i = 0; i < 10; i++) begin
            run(1'b0, vt[i].a, vt[i].b, lat, fl, busy_n);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_flags", i), fl, vt[i].flags);
            chk($sformatf("vec%0d_busy_cycles", i), busy_n, vt[i].lat);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i),
                {bus8.done, bus8.busy}, 2'b00);
            chk($sformatf("vec%0d_held", i), flags8(), vt[i].flags);
        end

        // Result held across idle cycles and operand changes.
        run(1'b0, 8'hC0, 8'h40, lat, fl, busy_n);
        chk("hold_lat", lat, 1);
        bus8.a = 8'h00;
        bus8.b = 8'hFF;
        repeat (4) @(negedge clk);
        chk("hold_flags", {bus8.done, bus8.busy, flags8()}, 5'b00100);

        // Start re-pulsed during CMP is ignored; operands change too.
        bus8.start = 1'b1;
        bus8.a     = 8'h12;
        bus8.b     = 8'h13;
        nd = 0;
        di = -1;
        fd = 3'b000;
        bb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                nd++;
                di = i;
                fd = flags8();
            end
            if (i >= 6) bb = bb | bus8.busy;
            if (i == 0) bus8.start = 1'b0;
            if (i == 1) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hFF;
            end
            if (i == 2) bus8.start = 1'b0;
        end
        chk("ignore_done_count", nd, 1);
        chk("ignore_done_cycle", di, 4);
        chk("ignore_flags", fd, 3'b001);
        chk("ignore_no_restart", bb, 1'b0);

        // Start held high: back-to-back with one idle cycle between.
        bus8.start = 1'b1;
        bus8.a     = 8'hC0;
        bus8.b     = 8'h40;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dpat[i] = bus8.done;
            bpat[i] = bus8.busy;
        end
        bus8.start = 1'b0;
        chk("b2b_done_pattern", dpat, 6'b010010);
        chk("b2b_busy_pattern", bpat, 6'b001001);

        // Reset on cycle 2 of a compare, then immediate restart.
        bus8.start = 1'b1;
        bus8.a     = 8'h12;
        bus8.b     = 8'h13;
        nd = 0;
        di = -1;
        fd = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                nd++;
                di = i;
                fd = flags8();
            end
            if (i == 2)
                chk("abort_outs_zero", {bus8.busy, bus8.done, flags8()},
                    5'b0);
            if (i == 0) bus8.start = 1'b0;
            if (i == 1) rst = 1'b1;
            if (i == 2) begin
                rst        = 1'b0;
                bus8.start = 1'b1;
            end
            if (i == 3) bus8.start = 1'b0;
        end
        chk("abort_done_count", nd, 1);
        chk("abort_done_cycle", di, 7);
        chk("abort_restart_flags", fd, 3'b001);

        // Exhaustive WIDTH=2.
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                run(1'b1, 8'(ai), 8'(bi), lat, fl, busy_n);
                chk($sformatf("w2_%0d_%0d_lat", ai, bi), lat, 1);
                chk($sformatf("w2_%0d_%0d_flags", ai, bi), fl,
                    {ai > bi, ai == bi, ai < bi});
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
